// File: rtl/memory_access_pkg.sv
// memory_access_pkg: opcode bit positions, access-size encodings and FSM states
// shared by the memory-access stage.
package memory_access_pkg;
    localparam int OPLEN_DEF  = 8;
    localparam int MEM_RD_BIT = 3;
    localparam int MEM_WR_BIT = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    // Lane offset after dropping the address bits that would break alignment.
    function automatic logic [1:0] eff_off(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_BYTE) ? a : (size == SZ_HALF) ? {a[1], 1'b0} : 2'b00;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_BYTE) ? 1'b0 : (size == SZ_HALF) ? a[0] : |a;
    endfunction
endpackage

// File: rtl/memory_access_lane_align.sv
// mem_lane_align: byte-enable and store-data lane replication, plus load lane
// extraction with sign/zero extension. Size 2'b11 behaves as a word.
module mem_lane_align
    import memory_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size_i,
    input  logic [1:0]      off_i,
    input  logic            zext_i,
    input  logic [XLEN-1:0] sdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] ldata_o
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        be_o    = (size_i == SZ_BYTE) ? 4'b0001 << off_i
                : (size_i == SZ_HALF) ? 4'b0011 << {off_i[1], 1'b0}
                : 4'b1111;
        wdata_o = (size_i == SZ_BYTE) ? {4{sdata_i[7:0]}}
                : (size_i == SZ_HALF) ? {2{sdata_i[15:0]}}
                : sdata_i;
        ldata_o = (size_i == SZ_BYTE) ? {{24{~zext_i & shifted[7]}}, shifted[7:0]}
                : (size_i == SZ_HALF) ? {{16{~zext_i & shifted[15]}}, shifted[15:0]}
                : rdata_i;
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: memory pipeline stage with a req/ack data-memory handshake.
// Optional MISALIGN_TRAP_EN: misaligned accesses are flagged and skip the bus.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OPLEN = OPLEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             phase_memory,
    input  logic             jump_state_em,
    input  logic [OPLEN-1:0] decoded_op_em,
    input  logic [4:0]       rdsel_em,
    input  logic [XLEN-1:0]  next_pc_em,
    input  logic [XLEN-1:0]  alu_out_em,
    input  logic [XLEN-1:0]  rs2data_em,
    input  logic [2:0]       funct3_em,
    output logic             jump_state_mw,
    output logic [OPLEN-1:0] decoded_op_mw,
    output logic [4:0]       rdsel_mw,
    output logic [XLEN-1:0]  next_pc_mw,
    output logic [XLEN-1:0]  alu_out_mw,
    output logic [XLEN-1:0]  mem_out_mw,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ack,
    input  logic [XLEN-1:0]  dmem_rdata,
`ifdef MISALIGN_TRAP_EN
    output logic             mem_misalign_mw,
`endif
    output logic             stall_memory
);
    mem_state_e       state_q;
    logic             jump_q;
    logic [OPLEN-1:0] op_q;
    logic [4:0]       rdsel_q;
    logic [XLEN-1:0]  next_pc_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  mem_out_q;
    logic             req_q;
    logic             store_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  sdata_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             zext_q;
    logic             mem_op;
    logic             mis;
    logic [3:0]       be;
    logic [XLEN-1:0]  wdata;
    logic [XLEN-1:0]  ldata;

    assign mem_op = decoded_op_em[MEM_RD_BIT] | decoded_op_em[MEM_WR_BIT];
    assign mis    = misaligned(funct3_em[1:0], alu_out_em[1:0]);

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .size_i  (size_q),
        .off_i   (off_q),
        .zext_i  (zext_q),
        .sdata_i (sdata_q),
        .rdata_i (dmem_rdata),
        .be_o    (be),
        .wdata_o (wdata),
        .ldata_o (ldata)
    );

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    assign mem_misalign_mw = misalign_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            jump_q    <= 1'b0;
            op_q      <= '0;
            rdsel_q   <= '0;
            next_pc_q <= '0;
            alu_q     <= '0;
            mem_out_q <= '0;
            req_q     <= 1'b0;
            store_q   <= 1'b0;
            addr_q    <= '0;
            sdata_q   <= '0;
            size_q    <= '0;
            off_q     <= '0;
            zext_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (phase_memory) begin
                    jump_q    <= jump_state_em;
                    op_q      <= decoded_op_em;
                    rdsel_q   <= rdsel_em;
                    next_pc_q <= next_pc_em;
                    alu_q     <= alu_out_em;
                    mem_out_q <= '0;
`ifdef MISALIGN_TRAP_EN
                    misalign_q <= mem_op & mis;
`endif
                    if (mem_op) begin
                        store_q <= decoded_op_em[MEM_WR_BIT];
                        addr_q  <= {alu_out_em[XLEN-1:2], 2'b00};
                        sdata_q <= rs2data_em;
                        size_q  <= funct3_em[1:0];
                        off_q   <= eff_off(funct3_em[1:0], alu_out_em[1:0]);
                        zext_q  <= funct3_em[2];
`ifdef MISALIGN_TRAP_EN
                        req_q   <= ~mis;
                        state_q <= mis ? ST_DONE : ST_REQ;
`else
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
`endif
                    end
                end
                ST_REQ: if (dmem_ack) begin
                    req_q     <= 1'b0;
                    mem_out_q <= store_q ? '0 : ldata;
                    state_q   <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Without the reset term a held phase_memory would show a stall during reset.
    assign stall_memory = rst_n & ((state_q == ST_IDLE & phase_memory & mem_op) | state_q == ST_REQ);

    assign jump_state_mw = jump_q;
    assign decoded_op_mw = op_q;
    assign rdsel_mw      = rdsel_q;
    assign next_pc_mw    = next_pc_q;
    assign alu_out_mw    = alu_q;
    assign mem_out_mw    = mem_out_q;
    assign dmem_req      = req_q;
    assign dmem_we       = req_q & store_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = req_q ? be : 4'b0000;
    assign dmem_wdata    = (req_q & store_q) ? wdata : '0;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: table vectors, directed corner sequences and random accesses
// checked against a byte-lane arithmetic model of the memory stage.
module tb_memory_access;
    import memory_access_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 phase_memory = 1'b0;
    logic                 jump_state_em = 1'b0;
    logic [OPLEN_DEF-1:0] decoded_op_em = '0;
    logic [4:0]           rdsel_em = '0;
    logic [31:0]          next_pc_em = '0;
    logic [31:0]          alu_out_em = '0;
    logic [31:0]          rs2data_em = '0;
    logic [2:0]           funct3_em = '0;
    logic                 jump_state_mw;
    logic [OPLEN_DEF-1:0] decoded_op_mw;
    logic [4:0]           rdsel_mw;
    logic [31:0]          next_pc_mw, alu_out_mw, mem_out_mw;
    logic                 dmem_req, dmem_we;
    logic [31:0]          dmem_addr, dmem_wdata;
    logic [3:0]           dmem_be;
    logic                 dmem_ack = 1'b0;
    logic [31:0]          dmem_rdata = '0;
    logic                 stall_memory;
`ifdef MISALIGN_TRAP_EN
    logic                 mem_misalign_mw;
`endif

    int vectors = 0;
    int miscompares = 0;

    localparam logic [OPLEN_DEF-1:0] OP_LD = OPLEN_DEF'(1) << MEM_RD_BIT;
    localparam logic [OPLEN_DEF-1:0] OP_ST = OPLEN_DEF'(1) << MEM_WR_BIT;

    memory_access dut (
        .clk(clk), .rst_n(rst_n), .phase_memory(phase_memory),
        .jump_state_em(jump_state_em), .decoded_op_em(decoded_op_em), .rdsel_em(rdsel_em),
        .next_pc_em(next_pc_em), .alu_out_em(alu_out_em), .rs2data_em(rs2data_em),
        .funct3_em(funct3_em), .jump_state_mw(jump_state_mw), .decoded_op_mw(decoded_op_mw),
        .rdsel_mw(rdsel_mw), .next_pc_mw(next_pc_mw), .alu_out_mw(alu_out_mw),
        .mem_out_mw(mem_out_mw), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
`ifdef MISALIGN_TRAP_EN
        .mem_misalign_mw(mem_misalign_mw),
`endif
        .stall_memory(stall_memory)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a, rs2, rd,
                          input int dly, output logic [3:0] be, output logic [31:0] wd, da, mo,
                          output logic we, output int nst, output logic rq);
        int w;
        w = 0; nst = 0; rq = 1'b0; be = '0; wd = '0; da = '0; we = 1'b0;
        decoded_op_em = st ? OP_ST : OP_LD;
        funct3_em = f3; alu_out_em = a; rs2data_em = rs2; dmem_rdata = rd;
        phase_memory = 1'b1;
        #1;
        for (int c = 0; c < 64; c++) begin
            if (!stall_memory) break;
            nst++;
            if (dmem_req) begin
                rq = 1'b1; be = dmem_be; wd = dmem_wdata; da = dmem_addr; we = dmem_we;
                if (w == dly) dmem_ack = 1'b1;
                else w++;
            end
            @(posedge clk); #1;
            phase_memory = 1'b0; dmem_ack = 1'b0;
            #1;
        end
        mo = mem_out_mw;
        @(posedge clk); #1;
    endtask

    // Expected bus/load behaviour from access size and byte lanes.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a, rs2, rd,
                                  input int dly, output logic [3:0] be, output logic [31:0] wd, da, mo,
                                  output logic we, output int nst, output logic rq);
        int n, off;
        logic [31:0] mask, v;
        n    = (f3[1:0] == 2'b11) ? 4 : (1 << f3[1:0]);
        off  = (int'(a[1:0]) / n) * n;
        da   = a & ~32'h3;
        be   = 4'(((1 << n) - 1) << off);
        wd   = '0;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % n) +: 8];
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
        v    = (rd >> (8 * off)) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        mo   = st ? 32'h0 : v;
        we   = st;
        nst  = dly + 2;
        rq   = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (int'(a[1:0]) % n != 0) begin
            be = '0; wd = '0; da = '0; mo = '0; we = 1'b0; nst = 1; rq = 1'b0;
        end
`endif
    endfunction

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, rs2, rd;
        int          dly;
        logic [3:0]  be;
        logic [31:0] wd, da, mo;
    } vec_t;

    initial begin
        vec_t        tbl [10];
        logic [3:0]  be, ebe;
        logic [31:0] wd, da, mo, ewd, eda, emo;
        logic        we, ewe, rq, erq;
        int          nst, enst;

        tbl[0] = '{1'b0, 3'b000, 32'h103, 32'h0,         32'h80AA_BBCC, 2, 4'b1000, 32'h0,         32'h100, 32'hFFFF_FF80};
        tbl[1] = '{1'b0, 3'b100, 32'h103, 32'h0,         32'h80AA_BBCC, 2, 4'b1000, 32'h0,         32'h100, 32'h0000_0080};
        tbl[2] = '{1'b1, 3'b001, 32'h202, 32'h1234_5678, 32'h0,         1, 4'b1100, 32'h5678_5678, 32'h200, 32'h0};
        tbl[3] = '{1'b0, 3'b001, 32'h102, 32'h0,         32'h80AA_BBCC, 0, 4'b1100, 32'h0,         32'h100, 32'hFFFF_80AA};
        tbl[4] = '{1'b0, 3'b101, 32'h100, 32'h0,         32'h80AA_BBCC, 3, 4'b0011, 32'h0,         32'h100, 32'h0000_BBCC};
        tbl[5] = '{1'b0, 3'b010, 32'h104, 32'h0,         32'h80AA_BBCC, 0, 4'b1111, 32'h0,         32'h104, 32'h80AA_BBCC};
        tbl[6] = '{1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'h0,         1, 4'b0010, 32'hABAB_ABAB, 32'h100, 32'h0};
        tbl[7] = '{1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF, 32'h300, 32'h0};
        tbl[8] = '{1'b0, 3'b011, 32'h108, 32'h0,         32'h1234_5678, 1, 4'b1111, 32'h0,         32'h108, 32'h1234_5678};
        tbl[9] = '{1'b0, 3'b000, 32'h101, 32'h0,         32'h80AA_BBCC, 1, 4'b0010, 32'h0,         32'h100, 32'hFFFF_FFBB};

        phase_memory = 1'b1;
        decoded_op_em = OP_LD;
        #2;
        chk("reset stall", 32'(stall_memory), 32'h0);
        chk("reset req", 32'(dmem_req), 32'h0);
        chk("reset mem_out", mem_out_mw, 32'h0);
        chk("reset alu_out", alu_out_mw, 32'h0);
        chk("reset be", 32'(dmem_be), 32'h0);
        phase_memory = 1'b0;
        decoded_op_em = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            access(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].rs2, tbl[i].rd, tbl[i].dly,
                   be, wd, da, mo, we, nst, rq);
            chk($sformatf("v%0d req", i), 32'(rq), 32'h1);
            chk($sformatf("v%0d be", i), 32'(be), 32'(tbl[i].be));
            chk($sformatf("v%0d addr", i), da, tbl[i].da);
            chk($sformatf("v%0d we", i), 32'(we), 32'(tbl[i].st));
            if (tbl[i].st) chk($sformatf("v%0d wdata", i), wd, tbl[i].wd);
            chk($sformatf("v%0d mem_out", i), mo, tbl[i].mo);
            chk($sformatf("v%0d stall cycles", i), 32'(nst), 32'(tbl[i].dly + 2));
        end

        // Non-memory op passes straight through, clearing stale load data.
        decoded_op_em = 8'h01; alu_out_em = 32'h2222_2222; rdsel_em = 5'd7;
        next_pc_em = 32'h1004; jump_state_em = 1'b1; phase_memory = 1'b1;
        #1;
        chk("nomem stall", 32'(stall_memory), 32'h0);
        chk("nomem req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        phase_memory = 1'b0;
        chk("nomem alu_out", alu_out_mw, 32'h2222_2222);
        chk("nomem rdsel", 32'(rdsel_mw), 32'd7);
        chk("nomem next_pc", next_pc_mw, 32'h1004);
        chk("nomem jump", 32'(jump_state_mw), 32'h1);
        chk("nomem op", 32'(decoded_op_mw), 32'h01);
        chk("nomem mem_out", mem_out_mw, 32'h0);
        chk("nomem stall after", 32'(stall_memory), 32'h0);
        chk("nomem req after", 32'(dmem_req), 32'h0);
        jump_state_em = 1'b0;

        // phase_memory during DONE and ack during IDLE are both ignored.
        decoded_op_em = OP_LD; funct3_em = 3'b010; alu_out_em = 32'h500;
        dmem_rdata = 32'hCAFE_F00D; phase_memory = 1'b1;
        @(posedge clk); #1;
        phase_memory = 1'b0;
        chk("done-seq req", 32'(dmem_req), 32'h1);
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("done-seq stall", 32'(stall_memory), 32'h0);
        decoded_op_em = '0; alu_out_em = 32'h7777_7777; phase_memory = 1'b1;
        @(posedge clk); #1;
        phase_memory = 1'b0;
        chk("done-seq alu_out kept", alu_out_mw, 32'h500);
        chk("done-seq mem_out", mem_out_mw, 32'hCAFE_F00D);
        dmem_rdata = 32'h0; dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("idle ack mem_out", mem_out_mw, 32'hCAFE_F00D);
        chk("idle ack req", 32'(dmem_req), 32'h0);

        // Asynchronous reset while a request is outstanding.
        decoded_op_em = OP_LD; funct3_em = 3'b010; alu_out_em = 32'h400; phase_memory = 1'b1;
        @(posedge clk); #1;
        phase_memory = 1'b0;
        chk("rst-seq req before", 32'(dmem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst-seq req async", 32'(dmem_req), 32'h0);
        chk("rst-seq stall", 32'(stall_memory), 32'h0);
        chk("rst-seq alu_out", alu_out_mw, 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_rdata = 32'hFFFF_FFFF; dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("rst-seq late ack mem_out", mem_out_mw, 32'h0);
        chk("rst-seq late ack req", 32'(dmem_req), 32'h0);
        chk("rst-seq late ack stall", 32'(stall_memory), 32'h0);
        @(posedge clk); #1;

        // Misaligned word load.
        access(1'b0, 3'b010, 32'h1001, 32'h0, 32'h1111_2222, 1, be, wd, da, mo, we, nst, rq);
`ifdef MISALIGN_TRAP_EN
        chk("mis req", 32'(rq), 32'h0);
        chk("mis flag", 32'(mem_misalign_mw), 32'h1);
        chk("mis stall cycles", 32'(nst), 32'h1);
`else
        chk("mis req", 32'(rq), 32'h1);
        chk("mis addr", da, 32'h1000);
        chk("mis be", 32'(be), 32'hF);
        chk("mis mem_out", mo, 32'h1111_2222);
`endif

        for (int i = 0; i < 60; i++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a, rs2, rd;
            logic [4:0]  rs;
            int          dly;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; rs2 = $urandom; rd = $urandom;
            dly = $urandom_range(0, 3);
            rs = 5'($urandom_range(0, 31));
            rdsel_em = rs;
            model(st, f3, a, rs2, rd, dly, ebe, ewd, eda, emo, ewe, enst, erq);
            access(st, f3, a, rs2, rd, dly, be, wd, da, mo, we, nst, rq);
            chk($sformatf("r%0d req", i), 32'(rq), 32'(erq));
            chk($sformatf("r%0d be", i), 32'(be), 32'(ebe));
            chk($sformatf("r%0d addr", i), da, eda);
            chk($sformatf("r%0d we", i), 32'(we), 32'(ewe));
            if (ewe) chk($sformatf("r%0d wdata", i), wd, ewd);
            chk($sformatf("r%0d mem_out", i), mo, emo);
            chk($sformatf("r%0d stall cycles", i), 32'(nst), 32'(enst));
            chk($sformatf("r%0d alu_out", i), alu_out_mw, a);
            chk($sformatf("r%0d rdsel", i), 32'(rdsel_mw), 32'(rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 Parameter OPLEN, default from the shared header: decoded-opcode width.
REQ-003 clk  in  1  single core clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 phase_memory  in  1  memory-phase strobe from the state machine.
REQ-006 jump_state_em, decoded_op_em[OPLEN], rdsel_em[5], next_pc_em[XLEN], alu_out_em[XLEN]  in  execute-stage results; alu_out_em doubles as the memory address.
REQ-007 rs2data_em  in  XLEN  store data; funct3_em  in  3  access size in [1:0] (00 byte, 01 half, 10 word), zero-extend in [2].
REQ-008 jump_state_mw, decoded_op_mw, rdsel_mw, next_pc_mw, alu_out_mw  out  registered copies for writeback; mem_out_mw  out  XLEN  extended load data.
REQ-009 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  XLEN; dmem_be  out  4; dmem_ack  in  1; dmem_rdata  in  XLEN.
REQ-010 stall_memory  out  1  holds the state machine in the memory phase.

Function
REQ-011 FSM states: IDLE, REQ, DONE.
REQ-012 IDLE: phase_memory=1 with neither MEM_RD_BIT nor MEM_WR_BIT set in decoded_op_em: capture all *_em inputs into the *_mw registers on that edge, set mem_out_mw=0, stay IDLE, stall_memory=0.
REQ-013 IDLE: phase_memory=1 with a load or store: capture pass-through fields and latch address, data, be and funct3; go to REQ; stall_memory is combinationally 1 in that same cycle.
REQ-014 REQ: dmem_req=1 (registered), dmem_we=1 for stores; address, wdata and be held stable until the cycle dmem_ack=1; stall_memory=1.
REQ-015 REQ with dmem_ack=1: a load captures extended data into mem_out_mw; a store leaves mem_out_mw at 0; go to DONE; dmem_req=0 next cycle.
REQ-016 DONE: stall_memory=0 for exactly one cycle, then return to IDLE. Minimum load/store latency is 3 cycles from the phase_memory edge to stall release.
REQ-017 dmem_addr = {alu_out[XLEN-1:2], 2'b00}.
REQ-018 Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
REQ-019 Store data is replicated across lanes: byte {4{b}}, half {2{h}}.
REQ-020 Load data: select the lane by addr[1:0], then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1).
REQ-021 funct3[1:0]=11 is treated as a word access.
REQ-022 dmem_ack outside REQ is ignored; phase_memory in REQ or DONE is ignored.

Reset
REQ-023 While rst_n=0: all outputs and registers are 0, the FSM is IDLE, and dmem_req deasserts immediately (asynchronously), including during an in-flight REQ; an ack after reset release is ignored.

Configuration
REQ-024 MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no request, sets output mem_misalign_mw=1 for that instruction, and goes straight to DONE.
REQ-025 MISALIGN_TRAP_EN undefined: no mem_misalign_mw port; low address bits that break alignment are forced to zero and the access proceeds.

Structure
REQ-026 MEM_RD_BIT, MEM_WR_BIT, the funct3 size encodings and the FSM state encodings live in core_general.vh.
REQ-027 One sub-module, mem_lane_align, holds the combinational be/wdata generation and the load lane extraction.

Verification
REQ-028 No-mem op, alu_out_em=32'h2222_2222, phase_memory pulse: alu_out_mw=32'h2222_2222 next edge, stall_memory never 1, dmem_req never 1.
REQ-029 LB at addr 0x103, rdata 32'h80AA_BBCC, ack 2 cycles after req: dmem_addr=0x100, be=1000, mem_out_mw=32'hFFFF_FF80; same access as LBU gives 32'h0000_0080.
REQ-030 SH at addr 0x202, rs2=32'h1234_5678: dmem_we=1, be=1100, wdata=32'h5678_5678, stall_memory released exactly one cycle after the ack cycle.
REQ-031 LW, then rst_n pulsed low while in REQ: dmem_req drops to 0 without a clock edge; a late ack leaves mem_out_mw=0.
REQ-032 LW at 0x1001: with MISALIGN_TRAP_EN, no dmem_req and mem_misalign_mw=1; without it, dmem_addr=0x1000 and be=1111.
